// File: rtl/matrix_result_collector_pkg.sv
// Shared definitions for the matrix result collector and its neighbours:
// default element/input widths, the collector state encoding and the
// MSB-first row-major slot offset used for every flattened matrix bus.
package matrix_result_collector_pkg;

  localparam int unsigned ELEM_W_DEF = 8;
  localparam int unsigned IN_W_DEF   = 65;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } collect_state_t;

  // MSB bit index of element (r,c) in a flattened row-major matrix whose
  // element (0,0) occupies the most significant field.
  function automatic int unsigned slot_msb(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned ncol,
                                           input int unsigned elem_w,
                                           input int unsigned total);
    return total - 1 - (r * ncol + c) * elem_w;
  endfunction

  // Index counter width; a single-entry dimension still gets one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_result_collector_if.sv
// Handshake bundle between the multiplier result stream, the collector
// and the matrix consumer. master = stream producer / consumer side,
// slave = collector.
interface matrix_result_collector_if
  import matrix_result_collector_pkg::*;
#(
  parameter int unsigned aRow   = 5,
  parameter int unsigned bCol   = 5,
  parameter int unsigned ELEM_W = ELEM_W_DEF,
  parameter int unsigned IN_W   = IN_W_DEF
) ();

  localparam int unsigned matrixRLen = aRow * bCol * ELEM_W;
  localparam int unsigned ROW_W      = idx_w(aRow);
  localparam int unsigned COL_W      = idx_w(bCol);

  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_data;
  logic [matrixRLen-1:0] mat_out;
  logic                  mat_valid;
  logic                  mat_ack;
  logic                  ovf;
  logic [ROW_W-1:0]      row_idx;
  logic [COL_W-1:0]      col_idx;

  modport master (
    output in_valid, in_data, mat_ack,
    input  in_ready, mat_out, mat_valid, ovf, row_idx, col_idx
  );

  modport slave (
    input  in_valid, in_data, mat_ack,
    output in_ready, mat_out, mat_valid, ovf, row_idx, col_idx
  );

endinterface

// File: rtl/matrix_result_collector_elem_clip.sv
// result_elem_clip: reduces an IN_W-bit dot product to an ELEM_W-bit
// stored element and flags values that do not fit.
// Build option: define RESULT_SAT_EN to saturate oversized values to all
// ones; otherwise they are truncated to their low ELEM_W bits.
module result_elem_clip
  import matrix_result_collector_pkg::*;
#(
  parameter int unsigned ELEM_W = ELEM_W_DEF,
  parameter int unsigned IN_W   = IN_W_DEF
) (
  input  logic [IN_W-1:0]   din,
  output logic [ELEM_W-1:0] dout,
  output logic              elem_ovf
);

  // Any set bit above the element field means the value exceeds 2^ELEM_W-1.
  always_comb begin
    elem_ovf = |din[IN_W-1:ELEM_W];
`ifdef RESULT_SAT_EN
    dout = elem_ovf ? '1 : din[ELEM_W-1:0];
`else
    dout = din[ELEM_W-1:0];
`endif
  end

endmodule

// File: rtl/matrix_result_collector.sv
// matrix_result_collector: assembles a row-major stream of dot products
// into a flattened aRow x bCol matrix and holds it for a valid/ack consumer.
// Build option: RESULT_SAT_EN (saturating clip, see result_elem_clip).
module matrix_result_collector
  import matrix_result_collector_pkg::*;
#(
  parameter int unsigned aRow       = 5,
  parameter int unsigned bCol       = 5,
  parameter int unsigned ELEM_W     = ELEM_W_DEF,
  parameter int unsigned IN_W       = IN_W_DEF,
  parameter int unsigned matrixRLen = aRow * bCol * ELEM_W
) (
  input  logic                        clk,
  input  logic                        rst,
  matrix_result_collector_if.slave    bus
);

  localparam int unsigned ROW_W = idx_w(aRow);
  localparam int unsigned COL_W = idx_w(bCol);

  collect_state_t        state;
  logic [matrixRLen-1:0] mat_r;
  logic                  ovf_r;
  logic [ROW_W-1:0]      row_r;
  logic [COL_W-1:0]      col_r;
  logic                  in_ready_r;
  logic                  mat_valid_r;

  logic [ELEM_W-1:0]     clip_d;
  logic                  clip_ovf;
  logic                  row_last;
  logic                  col_last;

  result_elem_clip #(
    .ELEM_W (ELEM_W),
    .IN_W   (IN_W)
  ) u_clip (
    .din      (bus.in_data),
    .dout     (clip_d),
    .elem_ovf (clip_ovf)
  );

  // Position of the current slot relative to the end of a row / the frame.
  always_comb begin
    row_last = (row_r == ROW_W'(aRow - 1));
    col_last = (col_r == COL_W'(bCol - 1));
  end

  // Collect/hold controller; the handshake outputs are registered alongside
  // the state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= COLLECT;
      mat_r       <= '0;
      ovf_r       <= 1'b0;
      row_r       <= '0;
      col_r       <= '0;
      in_ready_r  <= 1'b1;
      mat_valid_r <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (bus.in_valid) begin
            // Slot write decoded per element so each field has a fixed
            // bit range instead of a variable part-select.
            for (int unsigned r = 0; r < aRow; r++) begin
              for (int unsigned c = 0; c < bCol; c++) begin
                if (row_r == ROW_W'(r) && col_r == COL_W'(c)) begin
                  mat_r[slot_msb(r, c, bCol, ELEM_W, matrixRLen) -: ELEM_W] <= clip_d;
                end
              end
            end
            ovf_r <= ovf_r | clip_ovf;
            if (col_last) begin
              col_r <= '0;
              if (row_last) begin
                row_r       <= '0;
                state       <= HOLD;
                in_ready_r  <= 1'b0;
                mat_valid_r <= 1'b1;
              end else begin
                row_r <= row_r + ROW_W'(1);
              end
            end else begin
              col_r <= col_r + COL_W'(1);
            end
          end
        end
        HOLD: begin
          if (bus.mat_ack) begin
            state       <= COLLECT;
            in_ready_r  <= 1'b1;
            mat_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mat_valid = mat_valid_r;
  assign bus.mat_out   = mat_r;
  assign bus.ovf       = ovf_r;
  assign bus.row_idx   = row_r;
  assign bus.col_idx   = col_r;

endmodule

// File: tb/tb_matrix_result_collector.sv
// Scoreboard bench for matrix_result_collector: the stimulus side keeps a
// reference of accepted elements per frame and queues each completed
// frame; a monitor compares every presented frame and its stability.
module tb_matrix_result_collector;

  localparam int unsigned AR = 5;
  localparam int unsigned BC = 5;
  localparam int unsigned EW = 8;
  localparam int unsigned IW = 65;
  localparam int unsigned NE = AR * BC;
  localparam int unsigned MR = NE * EW;

  typedef struct {
    logic [MR-1:0] mat;
    bit            ovf;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  frame_t        sb[$];
  logic [IW-1:0] acc_q[$];
  bit            exp_hold = 1'b0;
  bit            exp_ovf  = 1'b0;

  matrix_result_collector_if #(.aRow(AR), .bCol(BC), .ELEM_W(EW), .IN_W(IW)) bus ();

  matrix_result_collector #(
    .aRow   (AR),
    .bCol   (BC),
    .ELEM_W (EW),
    .IN_W   (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [MR-1:0] act, input logic [MR-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] ref_clip(input logic [IW-1:0] d);
    logic [EW-1:0] lo;
    lo = d[EW-1:0];
`ifdef RESULT_SAT_EN
    if (d > IW'(255)) lo = '1;
`endif
    return lo;
  endfunction

  // Reference: the k-th accepted element of a frame lands in field k counted
  // from the MSB end; a frame completes after NE accepts.
  task automatic model_accept(input logic [IW-1:0] d);
    frame_t f;
    acc_q.push_back(d);
    if (d > IW'(255)) exp_ovf = 1'b1;
    if (acc_q.size() == NE) begin
      f.mat = '0;
      f.ovf = exp_ovf;
      for (int k = 0; k < NE; k++) f.mat[MR-1-k*EW -: EW] = ref_clip(acc_q[k]);
      sb.push_back(f);
      acc_q.delete();
      exp_hold = 1'b1;
    end
  endtask

  // One clock of stimulus with per-cycle handshake and index checks.
  task automatic drive(input bit v, input logic [IW-1:0] d, input bit ack);
    bit acc;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.mat_ack  = ack;
    @(negedge clk);
    chk("in_ready", bus.in_ready, !exp_hold);
    chk("mat_valid", bus.mat_valid, exp_hold);
    chk("ovf", bus.ovf, exp_ovf);
    acc = v && !exp_hold;
    @(posedge clk);
    #1;
    if (exp_hold && ack) begin
      exp_hold = 1'b0;
      exp_ovf  = 1'b0;
    end else if (acc) begin
      model_accept(d);
    end
    chk("row_idx", bus.row_idx, acc_q.size() / BC);
    chk("col_idx", bus.col_idx, acc_q.size() % BC);
    bus.in_valid = 1'b0;
    bus.mat_ack  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.mat_ack  = 1'b0;
    bus.in_data  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    acc_q.delete();
    exp_hold = 1'b0;
    exp_ovf  = 1'b0;
    chk("rst_mat_out", bus.mat_out, '0);
    chk("rst_mat_valid", bus.mat_valid, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);
    chk("rst_row_idx", bus.row_idx, 0);
    chk("rst_col_idx", bus.col_idx, 0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    rst = 1'b1;
  endtask

  function automatic logic [IW-1:0] rnd_val();
    logic [95:0] w;
    w = {$urandom, $urandom, $urandom};
    if ($urandom_range(0, 3) == 0) return w[IW-1:0];
    return IW'($urandom_range(0, 255));
  endfunction

  // Monitor: pop and compare on each new frame; hold the frame stable.
  logic [MR-1:0] held;
  bit            prev_valid = 1'b0;
  always @(negedge clk) begin
    frame_t f;
    if (rst && bus.mat_valid) begin
      if (!prev_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame", 1'b1, 1'b0);
        end else begin
          f = sb.pop_front();
          chk("frame_mat_out", bus.mat_out, f.mat);
          chk("frame_ovf", bus.ovf, f.ovf);
        end
        held = bus.mat_out;
      end else begin
        chk("hold_stable", bus.mat_out, held);
      end
    end
    prev_valid = rst && bus.mat_valid;
  end

  initial begin
    logic [IW-1:0] v;
    do_reset();

    // Rows of {15,30,45,60,75}.
    for (int unsigned k = 0; k < NE; k++) drive(1'b1, IW'((k % BC + 1) * 15), 1'b0);
    chk("first_row", bus.mat_out[MR-1 -: 40], {8'd15, 8'd30, 8'd45, 8'd60, 8'd75});
    drive(1'b0, '0, 1'b1);

    // Alternating valid, then elements offered while holding.
    for (int unsigned k = 0; k < NE; k++) begin
      drive(1'b1, rnd_val(), 1'b0);
      drive(1'b0, rnd_val(), 1'b0);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, rnd_val(), 1'b0);
    drive(1'b0, '0, 1'b1);

    // Single oversized element at (2,3).
    for (int unsigned k = 0; k < NE; k++) drive(1'b1, (k == 13) ? IW'(300) : IW'(1), 1'b0);
`ifdef RESULT_SAT_EN
    chk("slot_2_3", bus.mat_out[MR-1-13*EW -: EW], 8'd255);
`else
    chk("slot_2_3", bus.mat_out[MR-1-13*EW -: EW], 8'd44);
`endif
    chk("ovf_set", bus.ovf, 1'b1);
    drive(1'b0, '0, 1'b1);
    chk("ovf_cleared", bus.ovf, 1'b0);

    // Reset after 12 accepts, then a full frame of sevens.
    for (int i = 0; i < 12; i++) drive(1'b1, rnd_val(), 1'b0);
    do_reset();
    for (int unsigned k = 0; k < NE; k++) drive(1'b1, IW'(7), 1'b0);
    drive(1'b0, '0, 1'b1);

    // Back-to-back: ack as soon as valid rises, next frame immediately.
    for (int f = 0; f < 2; f++) begin
      for (int unsigned k = 0; k < NE; k++) drive(1'b1, rnd_val(), 1'b0);
      drive(1'b0, '0, 1'b1);
      chk("ready_after_ack", bus.in_ready, 1'b1);
    end

    // Ack while collecting is ignored.
    for (int i = 0; i < 7; i++) drive(1'b1, rnd_val(), 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, rnd_val(), 1'b1);
    for (int unsigned k = 7; k < NE; k++) drive(1'b1, rnd_val(), 1'b0);
    drive(1'b0, '0, 1'b1);

    // Random gaps, random acks, random hold durations.
    for (int f = 0; f < 4; f++) begin
      while (!exp_hold) begin
        v = rnd_val();
        drive($urandom_range(0, 2) != 0, v, $urandom_range(0, 4) == 0);
      end
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) drive($urandom_range(0, 1) == 1, rnd_val(), 1'b0);
      drive(1'b0, '0, 1'b1);
    end

    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0);
    chk("frames_outstanding", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_result_collector.md
Name: matrix_result_collector

Overview:
- Receives the serial stream of result elements from the sequential matrix multiplier, one dot product per handshake, in row-major order.
- Assembles the elements into the flattened result matrix, using the same packing as the multiplier's operand buses.
- Presents the complete matrix to downstream logic with a valid/ack handshake.
- Sits between the multiplier's result port and the result consumer (register file or bench).

Parameters:
- aRow, 5, rows of result (rows of A)
- bCol, 5, columns of result (columns of B)
- ELEM_W, 8, stored element width in bits
- IN_W, 65, width of incoming dot-product value
- matrixRLen, aRow*bCol*ELEM_W, width of flattened result bus

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-low reset
- in_valid  input  1  in_data holds a result element
- in_ready  output  1  collector accepts an element this cycle
- in_data  input  IN_W  unsigned dot-product value
- mat_out  output  matrixRLen  flattened result; element (r,c) at bits [matrixRLen-1-(r*bCol+c)*ELEM_W -: ELEM_W], so (0,0) is the MSB byte
- mat_valid  output  1  mat_out holds a complete frame
- mat_ack  input  1  consumer has taken mat_out
- ovf  output  1  sticky flag: some element of the current frame exceeded 2^ELEM_W-1
- row_idx  output  clog2(aRow)  row of the next expected element
- col_idx  output  clog2(bCol)  column of the next expected element

Behaviour:
- Reset (rst==0 at a clk edge): state COLLECT; mat_out=0, mat_valid=0, ovf=0, row_idx=0, col_idx=0; in_ready=1 from the first cycle after reset. Reset mid-frame discards all partial data.
- Accept: an element is accepted when in_valid && in_ready at the clk edge. Unaccepted in_data is ignored.
- States:
  - COLLECT: in_ready=1, mat_valid=0.
  - HOLD: in_ready=0, mat_valid=1.
- COLLECT, on accept:
  - write the clipped element into slot (row_idx,col_idx);
  - col_idx increments; at bCol-1 it wraps to 0 and row_idx increments.
  - ovf |= (in_data >= 2^ELEM_W).
- Last element: accept at (aRow-1,bCol-1) moves to HOLD. row_idx and col_idx wrap to 0. mat_valid is 1 on the cycle after that accept (latency 1 clk from final accept).
- HOLD:
  - mat_out is stable; in_valid is ignored (in_ready=0, upstream must stall).
  - mat_ack==1 moves to COLLECT on the next edge; mat_valid drops that edge. ovf clears on the same edge.
  - mat_ack while mat_valid=0 is ignored.
- Clipping: the stored element is in_data[ELEM_W-1:0] (truncation) unless the optional feature is enabled. All counters are unsigned and never exceed aRow-1 / bCol-1.
- Slot contents are not cleared between frames; every slot is overwritten before the next mat_valid.
- Degenerate aRow=bCol=1: a single accept goes straight to HOLD.

Optional Feature:
- Macro: RESULT_SAT_EN.
- Defined: an element with in_data >= 2^ELEM_W is stored as 2^ELEM_W-1 (all ones).
- Undefined: the element is truncated to its low ELEM_W bits.
- ovf behaves identically in both cases.

Decomposition:
- Shared package/include holds:
  - ELEM_W and IN_W defaults;
  - COLLECT/HOLD state encoding (1-bit, COLLECT=0, HOLD=1);
  - the element-slot offset function (MSB-first row-major), also used by the operand loaders.
- One natural sub-module, result_elem_clip: combinational IN_W to ELEM_W clip that also produces the overflow bit. RESULT_SAT_EN selects saturate vs truncate inside it.

Test Plan:
- Reset then stream 25 elements, row-major: 15,30,45,60,75 repeated for each of 5 rows (5x5 of 1..5 times itself) -> mat_valid=1 the cycle after the 25th accept; every row of mat_out = {8'd15,8'd30,8'd45,8'd60,8'd75}; ovf=0.
- Stall/back-pressure: in_valid toggled every other cycle, then extra elements driven while in HOLD -> only valid-cycle accepts counted; extra elements not accepted; mat_out unchanged until mat_ack.
- Overflow: element (2,3)=300, rest 1 -> ovf=1; slot (2,3)=8'd44 without RESULT_SAT_EN, 8'd255 with it; ovf=0 after mat_ack.
- Reset mid-frame: rst=0 after 12 accepts, then a full 25-element frame of value 7 -> mat_valid only after 25 post-reset accepts; all slots 8'd7; row_idx/col_idx=0 immediately after reset.
- Back-to-back frames: mat_ack asserted the cycle mat_valid rises, second frame streamed immediately -> in_ready=1 the cycle after ack; second mat_out contains only second-frame values.
- mat_ack asserted during COLLECT -> no state change; mat_valid stays 0.
